mem_wb_stage: RTL and testbench

- Memory/write-back pipeline stage that sits directly upstream of the register file.
- Takes retiring instructions from the EX/MEM boundary and waits on data-memory load responses.
- Aligns and extends load data, then drives the register-file write port (wb_data, wb_addr, wb_e) from registers.
- Stalls upstream while a load is outstanding.

---
 rtl/mem_wb_stage_pkg.sv | 46 ++++
 rtl/mem_wb_stage_ld_align.sv | 36 +++
 rtl/mem_wb_stage.sv | 117 +++++++++++
 tb/tb_mem_wb_stage.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage: widths, load-size encodings,
// FSM states and the captured-load context.
package mem_wb_stage_pkg;

   function automatic int unsigned CLOG2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r++;
      return r;
   endfunction

   localparam int unsigned IntSize  = 32;
   localparam int unsigned XLEN     = IntSize;
   localparam int unsigned NUM_REGS = 32;
   localparam int unsigned RSLEN    = CLOG2(NUM_REGS);

   localparam logic [XLEN-1:0] ZWord = '0;
   localparam logic            Rsten = 1'b1;

   localparam logic [1:0] LS_BYTE = 2'b00;
   localparam logic [1:0] LS_HALF = 2'b01;
   localparam logic [1:0] LS_WORD = 2'b10;

   typedef enum logic {S_IDLE, S_WAIT} state_e;

   typedef struct packed {
      logic [RSLEN-1:0] rd;
      logic             wen;
      logic [1:0]       size;
      logic             unsgn;
      logic [1:0]       lane;
   } ld_ctx_t;

   // Half loads need lane[0]=0; word loads (incl. 2'b11) need lane=0.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
      logic r;
      r = 1'b0;
      case (size)
         LS_BYTE: r = 1'b0;
         LS_HALF: r = lane[0];
         default: r = (lane != 2'b00);
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_wb_stage_ld_align.sv
// Load-data extraction: picks the addressed byte/half out of the
// little-endian response word and sign- or zero-extends it.
module ld_align
   import mem_wb_stage_pkg::*;
(
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      size,
   input  logic            unsgn,
   input  logic [1:0]      lane,
   output logic [XLEN-1:0] data_c
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[7:0];
      half_sel = rdata[15:0];
      data_c   = rdata;

      case (lane)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

      case (size)
         LS_BYTE: data_c = {{(XLEN-8){byte_sel[7] & ~unsgn}}, byte_sel};
         LS_HALF: data_c = {{(XLEN-16){half_sel[15] & ~unsgn}}, half_sel};
         default: data_c = rdata;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: retires ALU results directly, holds upstream while a load
// is outstanding, and drives the register-file write port from registers.
// Optional MISALIGN_TRAP_EN adds misalign_o and suppresses misaligned writes.
module mem_wb_stage
   import mem_wb_stage_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_valid,
   input  logic             ex_flush,
   input  logic             ex_wen,
   input  logic             ex_is_load,
   input  logic [1:0]       ex_ld_size,
   input  logic             ex_ld_unsigned,
   input  logic [RSLEN-1:0] ex_rd,
   input  logic [XLEN-1:0]  ex_alu_res,
   input  logic             dmem_rvalid,
   input  logic [XLEN-1:0]  dmem_rdata,
`ifdef MISALIGN_TRAP_EN
   output logic             misalign_o,
`endif
   output logic             stall_o,
   output logic [XLEN-1:0]  wb_data,
   output logic [RSLEN-1:0] wb_addr,
   output logic             wb_e
);

   state_e           state, state_n;
   ld_ctx_t          ctx, ctx_n;
   logic             wb_e_n;
   logic [RSLEN-1:0] wb_addr_n;
   logic [XLEN-1:0]  wb_data_n;
   logic [XLEN-1:0]  ld_data_c;
   logic             accept_c;
`ifdef MISALIGN_TRAP_EN
   logic             misalign_n;
`endif

   ld_align u_ld_align (
      .rdata  (dmem_rdata),
      .size   (ctx.size),
      .unsgn  (ctx.unsgn),
      .lane   (ctx.lane),
      .data_c (ld_data_c)
   );

   assign accept_c = ex_valid & ~ex_flush;
   // Upstream holds while the load is outstanding, including the rvalid cycle.
   assign stall_o  = (state == S_WAIT);

   always_ff @(posedge clk) begin
      if (rst == Rsten) begin
         state   <= S_IDLE;
         ctx     <= '0;
         wb_e    <= 1'b0;
         wb_addr <= '0;
         wb_data <= ZWord;
`ifdef MISALIGN_TRAP_EN
         misalign_o <= 1'b0;
`endif
      end else begin
         state   <= state_n;
         ctx     <= ctx_n;
         wb_e    <= wb_e_n;
         wb_addr <= wb_addr_n;
         wb_data <= wb_data_n;
`ifdef MISALIGN_TRAP_EN
         misalign_o <= misalign_n;
`endif
      end
   end

   always_comb begin
      state_n   = state;
      ctx_n     = ctx;
      wb_e_n    = 1'b0;
      wb_addr_n = wb_addr;
      wb_data_n = wb_data;
`ifdef MISALIGN_TRAP_EN
      misalign_n = 1'b0;
`endif

      case (state)
         S_IDLE: begin
            if (accept_c && ex_is_load) begin
               ctx_n.rd    = ex_rd;
               ctx_n.wen   = ex_wen;
               ctx_n.size  = ex_ld_size;
               ctx_n.unsgn = ex_ld_unsigned;
               ctx_n.lane  = ex_alu_res[1:0];
               state_n     = S_WAIT;
            end else if (accept_c && ex_wen && (ex_rd != '0)) begin
               wb_e_n    = 1'b1;
               wb_addr_n = ex_rd;
               wb_data_n = ex_alu_res;
            end
         end
         // Issued load is non-speculative: ex_valid/ex_flush ignored here.
         S_WAIT: begin
            if (dmem_rvalid) begin
               state_n   = S_IDLE;
               wb_addr_n = ctx.rd;
               wb_data_n = ld_data_c;
               wb_e_n    = ctx.wen & (ctx.rd != '0);
`ifdef MISALIGN_TRAP_EN
               if (is_misaligned(ctx.size, ctx.lane)) begin
                  misalign_n = 1'b1;
                  wb_e_n     = 1'b0;
               end
`endif
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage; follows MISALIGN_TRAP_EN
// when the build defines it.
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ex_valid = 1'b0;
   logic        ex_flush = 1'b0;
   logic        ex_wen = 1'b0;
   logic        ex_is_load = 1'b0;
   logic [1:0]  ex_ld_size = 2'b00;
   logic        ex_ld_unsigned = 1'b0;
   logic [4:0]  ex_rd = 5'd0;
   logic [31:0] ex_alu_res = 32'd0;
   logic        dmem_rvalid = 1'b0;
   logic [31:0] dmem_rdata = 32'd0;
   logic        stall_o;
   logic [31:0] wb_data;
   logic [4:0]  wb_addr;
   logic        wb_e;
`ifdef MISALIGN_TRAP_EN
   logic        misalign_o;
`endif

   int checks = 0;
   int errors = 0;

   mem_wb_stage dut (
      .clk            (clk),
      .rst            (rst),
      .ex_valid       (ex_valid),
      .ex_flush       (ex_flush),
      .ex_wen         (ex_wen),
      .ex_is_load     (ex_is_load),
      .ex_ld_size     (ex_ld_size),
      .ex_ld_unsigned (ex_ld_unsigned),
      .ex_rd          (ex_rd),
      .ex_alu_res     (ex_alu_res),
      .dmem_rvalid    (dmem_rvalid),
      .dmem_rdata     (dmem_rdata),
`ifdef MISALIGN_TRAP_EN
      .misalign_o     (misalign_o),
`endif
      .stall_o        (stall_o),
      .wb_data        (wb_data),
      .wb_addr        (wb_addr),
      .wb_e           (wb_e)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic alu_op(input logic [4:0] rd, input logic [31:0] res, input logic wen, input logic flush);
      ex_valid = 1'b1; ex_flush = flush; ex_is_load = 1'b0; ex_wen = wen;
      ex_rd = rd; ex_alu_res = res;
      step();
      ex_valid = 1'b0; ex_flush = 1'b0;
   endtask

   // Issue a load, let it sit n_wait cycles, then return rdata and check write-back.
   task automatic do_load(input string tag, input logic [4:0] rd, input logic [31:0] addr,
                          input logic [1:0] size, input logic uns, input logic wen,
                          input int n_wait, input logic [31:0] rdata,
                          input logic exp_we, input logic [31:0] exp_data);
      ex_valid = 1'b1; ex_is_load = 1'b1; ex_wen = wen; ex_rd = rd;
      ex_alu_res = addr; ex_ld_size = size; ex_ld_unsigned = uns;
      step();
      ex_valid = 1'b0; ex_is_load = 1'b0;
      for (int i = 0; i < n_wait; i++) begin
         check({tag, "_stall_wait"}, 32'(stall_o), 32'd1);
         check({tag, "_we_wait"}, 32'(wb_e), 32'd0);
         step();
      end
      check({tag, "_stall_rv"}, 32'(stall_o), 32'd1);
      dmem_rvalid = 1'b1; dmem_rdata = rdata;
      step();
      dmem_rvalid = 1'b0;
      check({tag, "_stall_after"}, 32'(stall_o), 32'd0);
      check({tag, "_we"}, 32'(wb_e), 32'(exp_we));
      check({tag, "_addr"}, 32'(wb_addr), 32'(rd));
      check({tag, "_data"}, wb_data, exp_data);
   endtask

   initial begin
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      check("rst_we", 32'(wb_e), 32'd0);
      check("rst_addr", 32'(wb_addr), 32'd0);
      check("rst_data", wb_data, 32'd0);
      check("rst_stall", 32'(stall_o), 32'd0);

      alu_op(5'd5, 32'h1234_5678, 1'b1, 1'b0);
      check("alu_we", 32'(wb_e), 32'd1);
      check("alu_addr", 32'(wb_addr), 32'd5);
      check("alu_data", wb_data, 32'h1234_5678);
      step();
      check("alu_we_drop", 32'(wb_e), 32'd0);
      check("alu_addr_hold", 32'(wb_addr), 32'd5);

      do_load("lb_s3", 5'd3, 32'h0000_1003, 2'b00, 1'b0, 1'b1, 1, 32'h80AA_BBCC, 1'b1, 32'hFFFF_FF80);
      step();
      check("lb_we_drop", 32'(wb_e), 32'd0);
      do_load("lbu_1", 5'd6, 32'h0000_2001, 2'b00, 1'b1, 1'b1, 0, 32'h80AA_BBCC, 1'b1, 32'h0000_00BB);
      do_load("lhu_hi", 5'd10, 32'h0000_0042, 2'b01, 1'b1, 1'b1, 2, 32'hBEEF_0001, 1'b1, 32'h0000_BEEF);
      do_load("lh_hi", 5'd11, 32'h0000_0042, 2'b01, 1'b0, 1'b1, 1, 32'hBEEF_0001, 1'b1, 32'hFFFF_BEEF);
      do_load("lh_lo", 5'd12, 32'h0000_0040, 2'b01, 1'b0, 1'b1, 0, 32'h1234_8001, 1'b1, 32'hFFFF_8001);
      do_load("lw", 5'd13, 32'h0000_0100, 2'b10, 1'b0, 1'b1, 0, 32'h7654_3210, 1'b1, 32'h7654_3210);
      do_load("lw11", 5'd14, 32'h0000_0100, 2'b11, 1'b0, 1'b1, 0, 32'h89AB_CDEF, 1'b1, 32'h89AB_CDEF);
      do_load("ld_rd0", 5'd0, 32'h0000_0000, 2'b10, 1'b0, 1'b1, 0, 32'h1111_1111, 1'b0, 32'h1111_1111);
      do_load("ld_nowen", 5'd15, 32'h0000_0000, 2'b10, 1'b0, 1'b0, 0, 32'h2222_2222, 1'b0, 32'h2222_2222);

      alu_op(5'd7, 32'h0000_DEAD, 1'b1, 1'b1);
      check("flush_we", 32'(wb_e), 32'd0);
      check("flush_addr_hold", 32'(wb_addr), 32'd15);
      alu_op(5'd0, 32'h0000_BEEF, 1'b1, 1'b0);
      check("rd0_we", 32'(wb_e), 32'd0);
      check("rd0_data_hold", wb_data, 32'h2222_2222);
      alu_op(5'd8, 32'h0000_0077, 1'b0, 1'b0);
      check("nowen_we", 32'(wb_e), 32'd0);

      alu_op(5'd1, 32'hAAAA_0001, 1'b1, 1'b0);
      check("b2b1_we", 32'(wb_e), 32'd1);
      check("b2b1_addr", 32'(wb_addr), 32'd1);
      alu_op(5'd2, 32'hAAAA_0002, 1'b1, 1'b0);
      check("b2b2_we", 32'(wb_e), 32'd1);
      check("b2b2_addr", 32'(wb_addr), 32'd2);
      check("b2b2_data", wb_data, 32'hAAAA_0002);

      dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_5555;
      step();
      dmem_rvalid = 1'b0;
      check("idle_rv_we", 32'(wb_e), 32'd0);
      check("idle_rv_stall", 32'(stall_o), 32'd0);
      check("idle_rv_data", wb_data, 32'hAAAA_0002);

      // ALU op presented during WAIT must not write; load write wins.
      ex_valid = 1'b1; ex_is_load = 1'b1; ex_wen = 1'b1; ex_rd = 5'd9;
      ex_alu_res = 32'h0000_0300; ex_ld_size = 2'b10; ex_ld_unsigned = 1'b0;
      step();
      ex_is_load = 1'b0; ex_rd = 5'd4; ex_alu_res = 32'h0000_4444;
      step();
      check("wait_ign_we", 32'(wb_e), 32'd0);
      check("wait_ign_stall", 32'(stall_o), 32'd1);
      ex_valid = 1'b1; ex_flush = 1'b1;
      step();
      ex_valid = 1'b0; ex_flush = 1'b0;
      check("wait_flush_stall", 32'(stall_o), 32'd1);
      check("wait_flush_we", 32'(wb_e), 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_stall", 32'(stall_o), 32'd0);
      check("mid_rst_addr", 32'(wb_addr), 32'd0);
      check("mid_rst_data", wb_data, 32'd0);
      dmem_rvalid = 1'b1; dmem_rdata = 32'h9999_9999;
      step();
      dmem_rvalid = 1'b0;
      check("post_rst_rv_we", 32'(wb_e), 32'd0);
      check("post_rst_rv_addr", 32'(wb_addr), 32'd0);
      check("post_rst_rv_stall", 32'(stall_o), 32'd0);

`ifdef MISALIGN_TRAP_EN
      check("mis_rst", 32'(misalign_o), 32'd0);
      do_load("lw_mis", 5'd20, 32'h0000_0502, 2'b10, 1'b0, 1'b1, 1, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D);
      check("mis_pulse", 32'(misalign_o), 32'd1);
      step();
      check("mis_drop", 32'(misalign_o), 32'd0);
      do_load("lh_mis", 5'd21, 32'h0000_0501, 2'b01, 1'b1, 1'b1, 0, 32'hCAFE_F00D, 1'b0, 32'h0000_F00D);
      check("lh_mis_pulse", 32'(misalign_o), 32'd1);
      do_load("lw_ok", 5'd22, 32'h0000_0500, 2'b10, 1'b0, 1'b1, 0, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D);
      check("lw_ok_nomis", 32'(misalign_o), 32'd0);
`else
      do_load("lw_mis", 5'd20, 32'h0000_0502, 2'b10, 1'b0, 1'b1, 1, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D);
      do_load("lh_odd", 5'd21, 32'h0000_0501, 2'b01, 1'b1, 1'b1, 0, 32'hCAFE_F00D, 1'b1, 32'h0000_F00D);
`endif
      step();
      check("final_we", 32'(wb_e), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
